// File: rtl/dht11_pkg.sv
// dht11_pkg: shared FSM states, status codes and default timing for the DHT11 read scheduler
package dht11_pkg;
  typedef enum logic [2:0] {S_IDLE, S_ARB, S_GAPWAIT, S_KICK, S_RUN, S_CHECK, S_RETRY, S_RESP} state_t;
  typedef enum logic [1:0] {ST_OK, ST_CRC_ERR, ST_SENSOR_ERR, ST_TIMEOUT} status_t;
  localparam int DEF_CLK_HZ    = 50_000_000;
  localparam int DEF_GAP_MS    = 2000;
  localparam int DEF_TMO_MS    = 50;
  localparam int DEF_MAX_RETRY = 3;
endpackage

// File: rtl/dht11_crc_chk.sv
// dht11_crc_chk: checks that the four DHT11 data bytes sum (mod 256) to the trailing crc byte
module dht11_crc_chk (
  input  logic [39:0] data,
  output logic        ok
);
  assign ok = 8'(data[39:32] + data[31:24] + data[23:16] + data[15:8]) == data[7:0];
endmodule

// File: rtl/dht11_read_sched.sv
// dht11_read_sched: arbitrates two requesters onto one DHT11 reader with gap pacing, watchdog and retries
module dht11_read_sched import dht11_pkg::*; #(
  parameter int CLK_HZ      = DEF_CLK_HZ,
  parameter int MIN_GAP_CYC = CLK_HZ / 1000 * DEF_GAP_MS,
  parameter int RUN_TMO_CYC = CLK_HZ / 1000 * DEF_TMO_MS,
  parameter int MAX_RETRY   = DEF_MAX_RETRY
) (
  input  logic        CLK,
  input  logic        RST,
  input  logic [1:0]  REQ,
  output logic [1:0]  GNT,
  output logic        BUSY,
  output logic [1:0]  STATUS,
  output logic [7:0]  HUM_INT,
  output logic [7:0]  HUM_FRAC,
  output logic [7:0]  TEMP_INT,
  output logic [7:0]  TEMP_FRAC,
  output logic        RDR_EN,
  output logic        RDR_RST,
  input  logic        RDR_DONE,
  input  logic        RDR_ERR,
  input  logic [39:0] RDR_DATA
);
  localparam int GW = $clog2(MIN_GAP_CYC + 1);
  localparam int WW = $clog2(RUN_TMO_CYC + 1);
  localparam int AW = $clog2(MAX_RETRY + 2);
  localparam logic [GW-1:0] GAP_MAX = GW'(MIN_GAP_CYC);
  localparam logic [WW-1:0] TMO_MAX = WW'(RUN_TMO_CYC);
  localparam logic [AW-1:0] ATT_MAX = AW'(MAX_RETRY);
  state_t state_q, state_d;
  status_t cause_q, cause_d, status_q, status_d;
  logic [GW-1:0] gap_q, gap_d;
  logic [WW-1:0] wdog_q, wdog_d;
  logic [AW-1:0] att_q, att_d;
  logic [1:0] sel_q, sel_d, gnt_q, gnt_d;
  logic last_q, last_d, busy_q, busy_d, en_q, en_d, rrst_q, rrst_d, crc_ok;
  logic [31:0] data_q, data_d;
  dht11_crc_chk u_crc (.data(RDR_DATA), .ok(crc_ok));
  always_comb begin
    state_d = state_q;
    cause_d = cause_q;
    gap_d   = (gap_q == GAP_MAX) ? gap_q : gap_q + 1'b1;
    wdog_d  = wdog_q;
    att_d   = att_q;
    sel_d   = sel_q;
    last_d  = last_q;
    unique case (state_q)
      S_IDLE:    state_d = |REQ ? S_ARB : S_IDLE;
      S_ARB: begin
        sel_d   = &REQ ? (last_q ? 2'b01 : 2'b10) : REQ;
        state_d = |REQ ? S_GAPWAIT : S_IDLE;
      end
      S_GAPWAIT: state_d = (gap_q == GAP_MAX) ? S_KICK : S_GAPWAIT;
      S_KICK: begin
        gap_d   = '0;
        wdog_d  = '0;
        state_d = S_RUN;
      end
      S_RUN: begin
        wdog_d  = wdog_q + 1'b1;
        state_d = RDR_DONE ? S_CHECK : (wdog_d == TMO_MAX) ? S_RETRY : S_RUN;
        cause_d = (!RDR_DONE && wdog_d == TMO_MAX) ? ST_TIMEOUT : cause_q;
      end
      S_CHECK: begin
        cause_d = RDR_ERR ? ST_SENSOR_ERR : crc_ok ? ST_OK : ST_CRC_ERR;
        state_d = (cause_d == ST_OK) ? S_RESP : S_RETRY;
      end
      S_RETRY: begin
        att_d   = (att_q < ATT_MAX) ? att_q + 1'b1 : att_q;
        state_d = (att_q < ATT_MAX) ? S_GAPWAIT : S_RESP;
      end
      S_RESP: begin
        att_d   = '0;
        last_d  = ~last_q;
        state_d = S_IDLE;
      end
      default:   state_d = S_IDLE;
    endcase
    gnt_d    = (state_d == S_RESP) ? sel_q : 2'b00;
    status_d = (state_d == S_RESP) ? cause_d : status_q;
    data_d   = (state_q == S_CHECK && cause_d == ST_OK) ? RDR_DATA[39:8] : data_q;
    busy_d   = state_d != S_IDLE;
    en_d     = state_d == S_KICK || state_d == S_RUN;
    rrst_d   = state_d == S_KICK;
  end
  // Gap counter resets saturated so the first transaction after reset kicks immediately
  always_ff @(posedge CLK) begin
    if (RST) begin
      state_q  <= S_IDLE;
      cause_q  <= ST_OK;
      status_q <= ST_OK;
      gap_q    <= GAP_MAX;
      wdog_q   <= '0;
      att_q    <= '0;
      sel_q    <= 2'b00;
      gnt_q    <= 2'b00;
      last_q   <= 1'b1;
      busy_q   <= 1'b0;
      en_q     <= 1'b0;
      rrst_q   <= 1'b0;
      data_q   <= '0;
    end else begin
      state_q  <= state_d;
      cause_q  <= cause_d;
      status_q <= status_d;
      gap_q    <= gap_d;
      wdog_q   <= wdog_d;
      att_q    <= att_d;
      sel_q    <= sel_d;
      gnt_q    <= gnt_d;
      last_q   <= last_d;
      busy_q   <= busy_d;
      en_q     <= en_d;
      rrst_q   <= rrst_d;
      data_q   <= data_d;
    end
  end
  assign GNT       = gnt_q;
  assign BUSY      = busy_q;
  assign STATUS    = status_q;
  assign HUM_INT   = data_q[31:24];
  assign HUM_FRAC  = data_q[23:16];
  assign TEMP_INT  = data_q[15:8];
  assign TEMP_FRAC = data_q[7:0];
  assign RDR_EN    = en_q;
  assign RDR_RST   = rrst_q;
endmodule

// File: tb/tb_dht11_read_sched.sv
// tb_dht11_read_sched: randomized and directed checks of the read scheduler against a transaction-level model
module tb_dht11_read_sched;
  localparam int GAP = 100, TMO = 50, MR = 2;
  logic CLK = 0, RST = 1, RDR_DONE = 0, RDR_ERR = 0;
  logic [1:0] REQ = 0;
  logic [39:0] RDR_DATA = 0;
  logic [1:0] GNT, STATUS;
  logic BUSY, RDR_EN, RDR_RST;
  logic [7:0] HUM_INT, HUM_FRAC, TEMP_INT, TEMP_FRAC;
  typedef struct {int kind; int lat; logic [39:0] data;} att_t;
  att_t rdr_q[$], mdl_q[$];
  int kick_cyc[$], en_runs[$];
  logic [1:0] g_log[$];
  int n_chk = 0, n_pass = 0, cyc = 0, en_len = 0, req_cyc = 0;
  logic [31:0] m_data;
  bit m_last;

  dht11_read_sched #(.CLK_HZ(1_000_000), .MIN_GAP_CYC(GAP), .RUN_TMO_CYC(TMO), .MAX_RETRY(MR)) dut (
    .CLK(CLK), .RST(RST), .REQ(REQ), .GNT(GNT), .BUSY(BUSY), .STATUS(STATUS),
    .HUM_INT(HUM_INT), .HUM_FRAC(HUM_FRAC), .TEMP_INT(TEMP_INT), .TEMP_FRAC(TEMP_FRAC),
    .RDR_EN(RDR_EN), .RDR_RST(RDR_RST), .RDR_DONE(RDR_DONE), .RDR_ERR(RDR_ERR), .RDR_DATA(RDR_DATA));

  always #5 CLK = ~CLK;

  initial begin
    #3_000_000;
    $display("FAIL global_timeout");
    $fatal(1);
  end

  // Reader model: each KICK starts the next planned attempt; kind 0 data, 1 sensor error, 2 never done
  initial begin
    att_t a;
    int cnt;
    bit act;
    act = 0;
    cnt = 0;
    a = '{0, 0, 40'h0};
    forever begin
      @(negedge CLK);
      if (RDR_RST) begin
        RDR_DONE = 0;
        RDR_ERR = 0;
        cnt = 0;
        act = rdr_q.size() > 0;
        if (act) a = rdr_q.pop_front();
      end else if (RDR_EN && act && !RDR_DONE) begin
        cnt++;
        if (a.kind != 2 && cnt == a.lat) begin
          RDR_DONE = 1;
          RDR_ERR = a.kind == 1;
          RDR_DATA = a.data;
        end
      end
    end
  end

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
  endtask

  task automatic step();
    @(posedge CLK);
    #1;
    cyc++;
    if (RDR_RST) kick_cyc.push_back(cyc);
    if (RDR_EN) en_len++;
    else if (en_len > 0) begin
      en_runs.push_back(en_len);
      en_len = 0;
    end
  endtask

  task automatic do_reset();
    RST = 1;
    REQ = 0;
    rdr_q.delete();
    mdl_q.delete();
    repeat (3) step();
    RST = 0;
    m_last = 1;
    m_data = 0;
    kick_cyc.delete();
    en_runs.delete();
    g_log.delete();
    en_len = 0;
  endtask

  task automatic add(input int kind, input int lat, input logic [39:0] data);
    rdr_q.push_back('{kind, lat, data});
    mdl_q.push_back('{kind, lat, data});
  endtask

  function automatic logic [39:0] mk(input logic [31:0] d, input bit good);
    logic [7:0] c;
    c = d[31:24] + d[23:16] + d[15:8] + d[7:0];
    if (!good) c = c + 8'($urandom_range(1, 255));
    return {d, c};
  endfunction

  // Model: winner by round robin, then attempts until OK or retries exhausted; status from the last attempt
  task automatic run_req(input logic [1:0] r);
    logic [1:0] pend, exp_g;
    att_t a;
    int n, st, k0, wd;
    bit gap_ok;
    pend = r;
    REQ = r;
    req_cyc = cyc;
    while (pend != 0) begin
      exp_g = (pend == 2'b11) ? (m_last ? 2'b01 : 2'b10) : pend;
      m_last = ~m_last;
      n = 0;
      st = 0;
      a = '{0, 0, 40'h0};
      do begin
        n++;
        if (mdl_q.size() == 0) st = 3;
        else begin
          a = mdl_q.pop_front();
          st = (a.kind == 2 || a.lat > TMO) ? 3 : (a.kind == 1) ? 2 :
               ((int'(a.data[39:32]) + int'(a.data[31:24]) + int'(a.data[23:16]) + int'(a.data[15:8])) % 256 == int'(a.data[7:0])) ? 0 : 1;
        end
      end while (st != 0 && n <= MR);
      if (st == 0) m_data = a.data[39:8];
      k0 = kick_cyc.size();
      wd = 0;
      do begin
        step();
        wd++;
      end while (GNT == 0 && wd < 3000);
      if (GNT == 0) begin
        chk("gnt_wait_expired", 64'(GNT), 64'(exp_g));
        return;
      end
      g_log.push_back(GNT);
      chk("gnt", 64'(GNT), 64'(exp_g));
      chk("status", 64'(STATUS), 64'(st));
      chk("data", {32'h0, HUM_INT, HUM_FRAC, TEMP_INT, TEMP_FRAC}, 64'(m_data));
      chk("kicks", 64'(kick_cyc.size() - k0), 64'(n));
      if (st == 0 && kick_cyc.size() > 0) chk("kick_to_gnt", 64'(cyc - kick_cyc[$]), 64'(a.lat + 2));
      gap_ok = 1;
      for (int i = 1; i < kick_cyc.size(); i++) if (kick_cyc[i] - kick_cyc[i-1] < GAP) gap_ok = 0;
      chk("gap", 64'(gap_ok), 64'(1));
      pend = pend & ~GNT;
      REQ = pend;
      step();
      chk("gnt_pulse", 64'(GNT), 64'(0));
    end
  endtask

  initial begin
    int wd;
    bit seen;
    repeat (2) step();
    chk("rst_gnt", 64'(GNT), 0);
    chk("rst_busy", 64'(BUSY), 0);
    chk("rst_status", 64'(STATUS), 0);
    chk("rst_data", {32'h0, HUM_INT, HUM_FRAC, TEMP_INT, TEMP_FRAC}, 0);
    chk("rst_en", 64'(RDR_EN), 0);
    chk("rst_rrst", 64'(RDR_RST), 0);

    do_reset();
    add(0, 10, 40'h3C00190055);
    run_req(2'b01);
    chk("basic_first_kick", 64'(kick_cyc[0] - req_cyc), 3);
    chk("basic_hum", 64'(HUM_INT), 64'h3C);
    chk("basic_temp", 64'(TEMP_INT), 64'h19);
    chk("basic_idle", 64'(BUSY), 0);

    do_reset();
    add(0, 12, mk($urandom, 1));
    add(0, 7, mk($urandom, 1));
    run_req(2'b11);
    chk("rr_first", 64'(g_log[0]), 64'(2'b01));
    chk("rr_second", 64'(g_log[1]), 64'(2'b10));
    chk("rr_gap", 64'(kick_cyc[1] - kick_cyc[0] >= GAP), 1);

    do_reset();
    add(0, 8, 40'h3C00190055);
    run_req(2'b01);
    repeat (3) add(0, 8, 40'h3C00190056);
    run_req(2'b01);
    chk("crc_status", 64'(STATUS), 1);
    chk("crc_hold", 64'(HUM_INT), 64'h3C);

    do_reset();
    repeat (3) add(2, 0, 40'h0);
    run_req(2'b10);
    chk("tmo_runs", 64'(en_runs.size()), 3);
    foreach (en_runs[i]) chk("tmo_len", 64'(en_runs[i]), 64'(TMO + 1));

    do_reset();
    add(1, 9, mk($urandom, 1));
    add(0, 9, mk($urandom, 1));
    run_req(2'b01);
    chk("err_retry_kicks", 64'(kick_cyc.size()), 2);

    do_reset();
    add(0, TMO, mk($urandom, 1));
    run_req(2'b01);
    add(0, TMO + 1, mk($urandom, 1));
    add(0, 4, mk($urandom, 1));
    run_req(2'b10);

    do_reset();
    add(2, 0, 40'h0);
    REQ = 2'b01;
    wd = 0;
    while (!(RDR_EN && !RDR_RST) && wd < 100) begin
      step();
      wd++;
    end
    repeat (5) step();
    chk("abort_in_run", 64'(RDR_EN), 1);
    RST = 1;
    step();
    RST = 0;
    REQ = 0;
    chk("abort_busy", 64'(BUSY), 0);
    chk("abort_en", 64'(RDR_EN), 0);
    seen = 0;
    repeat (20) begin
      step();
      if (GNT != 0) seen = 1;
    end
    chk("abort_no_gnt", 64'(seen), 0);
    rdr_q.delete();
    mdl_q.delete();
    kick_cyc.delete();
    m_last = 1;
    add(0, 6, mk($urandom, 1));
    run_req(2'b01);
    chk("abort_nogap_kick", 64'(kick_cyc[0] - req_cyc), 3);

    do_reset();
    for (int t = 0; t < 10; t++) begin
      logic [1:0] p;
      p = 2'($urandom_range(1, 3));
      for (int g = 0; g < (p == 2'b11 ? 2 : 1); g++)
        for (int k = 0; k <= MR; k++) begin
          int r, lat;
          r = $urandom_range(0, 4);
          lat = $urandom_range(1, 55);
          add(r == 3 ? 1 : r == 4 ? 2 : 0, lat, mk($urandom, r != 2));
          if (r < 2 && lat <= TMO) break;
        end
      run_req(p);
    end

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule

// File: doc/dht11_read_sched.md
DHT11_READ_SCHED -- requirements
Module: dht11_read_sched

Interface
REQ-001 Parameter CLK_HZ, default 50_000_000, system clock frequency.
REQ-002 Parameter MIN_GAP_CYC, default 100_000_000, minimum cycles between successive sensor transaction starts (2 s).
REQ-003 Parameter RUN_TMO_CYC, default 2_500_000, per-transaction watchdog (50 ms).
REQ-004 Parameter MAX_RETRY, default 3, extra attempts after a failed transaction.
REQ-005 Ports: CLK in 1, system clock; RST in 1, reset, synchronous, active-high.
REQ-006 REQ in 2, read requests from requester 0 and requester 1; level, held until GNT.
REQ-007 GNT out 2, one-cycle one-hot pulse; result outputs are valid in that cycle.
REQ-008 BUSY out 1, high whenever the FSM is not in IDLE.
REQ-009 STATUS out 2, 00 OK, 01 CRC_ERR, 10 SENSOR_ERR, 11 TIMEOUT; updated with GNT.
REQ-010 HUM_INT, HUM_FRAC, TEMP_INT, TEMP_FRAC out 8 each, last result; updated only when STATUS=OK.
REQ-011 RDR_EN out 1 and RDR_RST out 1, enable and reset to the DHT11 reader.
REQ-012 RDR_DONE in 1, RDR_ERR in 1, RDR_DATA in 40 (hum_int, hum_frac, temp_int, temp_frac, crc, MSB byte first), from the reader.

Function
REQ-013 FSM states: IDLE, ARB, GAPWAIT, KICK, RUN, CHECK, RETRY, RESP.
REQ-014 IDLE: when REQ nonzero, go to ARB next cycle.
REQ-015 ARB: grant by round robin; last_grant flips after every GNT; the requester other than last_grant wins when both are asserted; after reset requester 0 has priority.
REQ-016 GAPWAIT: gap counter counts cycles since the last KICK and saturates at MIN_GAP_CYC; leave for KICK once the count equals MIN_GAP_CYC; the first transaction after reset has no wait.
REQ-017 KICK: exactly one cycle with RDR_EN=1 and RDR_RST=1; clear the gap counter and the watchdog; then go to RUN.
REQ-018 RUN: RDR_EN=1, RDR_RST=0. On RDR_DONE=1 go to CHECK. When the watchdog reaches RUN_TMO_CYC, go to RETRY with cause TIMEOUT.
REQ-019 CHECK: one cycle; set RDR_EN=0.
- RDR_ERR=1: cause is SENSOR_ERR.
- Otherwise, compare (sum of the four data bytes) mod 256 with the crc byte; a mismatch gives cause CRC_ERR, a match gives OK.
- OK: latch the data bytes and go to RESP.
- Any failure: go to RETRY.
REQ-020 RETRY: if the attempt counter is below MAX_RETRY, increment it and go to GAPWAIT; otherwise go to RESP with STATUS equal to the last cause.
REQ-021 RESP: one cycle; GNT pulses on the granted bit; clear the attempt counter; return to IDLE.
REQ-022 Latency: from KICK, one transaction needs one cycle plus the reader time plus one CHECK cycle; GNT follows CHECK by exactly one cycle.
REQ-023 A requester that deasserts REQ mid-transaction still receives its GNT; a newly asserted REQ is not sampled until IDLE.
REQ-024 RDR_EN is low in IDLE, ARB, GAPWAIT, CHECK, RETRY and RESP, so the reader is frozen between transactions.
REQ-025 When RDR_DONE and the watchdog limit occur in the same cycle, RDR_DONE wins.
REQ-026 A timeout does not wait for the reader's internal error hold-off; the next KICK re-initialises the reader.

Reset
REQ-027 While RST=1, all of these are forced to 0: GNT, BUSY, STATUS, the data outputs, RDR_EN, RDR_RST, and the attempt counter. The FSM goes to IDLE, last_grant becomes 1, and the gap counter is set to MIN_GAP_CYC.
REQ-028 RST asserted during RUN aborts the transaction without a GNT; RDR_EN drops in the next cycle.

Structure
REQ-029 Shared package dht11_pkg holds the state enum, the STATUS codes and the default timing constants.
REQ-030 The checksum compare is a natural sub-module, dht11_crc_chk (40-bit data in, ok out, combinational).
REQ-031 Counter widths are derived from the parameters: gap counter 27 bits at default, watchdog 22 bits at default.

Verification (MIN_GAP_CYC=100, RUN_TMO_CYC=50, MAX_RETRY=2, behavioural reader model)
REQ-032 REQ=01, reader returns 0x3C_00_19_00_55 -> GNT=01, STATUS=00, HUM_INT=0x3C, TEMP_INT=0x19, one KICK.
REQ-033 REQ=11 held, both good reads -> GNT order 01 then 10, second KICK at least 100 cycles after the first.
REQ-034 Reader returns crc 0x56 for the data above -> three KICKs, then GNT with STATUS=01; data outputs unchanged from the prior value.
REQ-035 Reader never asserts RDR_DONE -> watchdog fires 50 cycles after each KICK, three attempts, STATUS=11.
REQ-036 Reader returns error on the first attempt and good data on the second -> STATUS=00, exactly two KICKs.
REQ-037 RST pulsed mid-RUN -> no GNT, BUSY=0 and RDR_EN=0 one cycle later; the next REQ kicks with no gap wait.
